// File: rtl/icache_req_arb.sv
// rtl/icache_req_arb.sv - demand/prefetch arbiter and outstanding-request tracker for the icache port
module icache_req_arb #(
    parameter int N_OUTST     = 4,
    parameter int STARVE_MAX  = 3,
    parameter int ID_W        = 4,
    parameter int CL_SZ_WORDS = 4,
    parameter int SLOT_W      = (N_OUTST > 1) ? $clog2(N_OUTST) : 1,
    parameter int LINE_W      = CL_SZ_WORDS * 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dm_req_valid,
    output logic              dm_req_ready,
    input  logic [31:0]       dm_req_addr,
    input  logic [ID_W-1:0]   dm_req_id,
    input  logic              pf_req_valid,
    output logic              pf_req_ready,
    input  logic [31:0]       pf_req_addr,
    input  logic [ID_W-1:0]   pf_req_id,
    input  logic              flush,
    output logic              ic_req_valid,
    output logic [31:0]       ic_req_addr,
    output logic [SLOT_W-1:0] ic_req_id,
    input  logic              ic_rsp_valid,
    input  logic [SLOT_W-1:0] ic_rsp_id,
    input  logic [LINE_W-1:0] ic_rsp_data,
    output logic              dm_rsp_valid,
    output logic [ID_W-1:0]   dm_rsp_id,
    output logic [LINE_W-1:0] dm_rsp_data,
    output logic              pf_rsp_valid,
    output logic [ID_W-1:0]   pf_rsp_id,
    output logic [LINE_W-1:0] pf_rsp_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    // Slot table: src 0 = demand, 1 = prefetch; killed marks demand lines made stale by flush
    logic [N_OUTST-1:0] slot_valid;
    logic [N_OUTST-1:0] slot_src;
    logic [N_OUTST-1:0] slot_killed;
    logic [ID_W-1:0]    slot_orig_id [N_OUTST];
    logic [CNT_W-1:0]   starve_cnt;

    logic              free_avail;
    logic [SLOT_W-1:0] free_idx;
    logic              dm_grant;
    logic              pf_grant;
    logic              grant;
    logic              rsp_live;
    logic              rsp_src;
    logic [ID_W-1:0]   rsp_orig_id;

    // Lowest-index free slot, taken from registered state only (no reuse of a slot freed this cycle)
    always_comb begin
        free_idx = '0;
        for (int i = N_OUTST - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
    end

    assign free_avail = ~&slot_valid;

    // Demand normally wins; it backs off during flush and when the prefetcher has waited too long
    assign dm_req_ready = free_avail & ~flush & ~reset
                        & ~(pf_req_valid & (starve_cnt == STARVE_LIM));
    assign pf_req_ready = free_avail & ~reset & ~(dm_req_valid & dm_req_ready);

    assign dm_grant = dm_req_valid & dm_req_ready;
    assign pf_grant = pf_req_valid & pf_req_ready;
    assign grant    = dm_grant | pf_grant;

    assign ic_req_valid = grant;
    assign ic_req_addr  = dm_grant ? dm_req_addr : pf_req_addr;
    assign ic_req_id    = free_idx;

    // Response lookup: route live lines back to their requester with the original id
    always_comb begin
        rsp_live    = ic_rsp_valid & slot_valid[ic_rsp_id] & ~slot_killed[ic_rsp_id];
        rsp_src     = slot_src[ic_rsp_id];
        rsp_orig_id = slot_orig_id[ic_rsp_id];
    end

    // A demand line landing in the flush cycle is already stale, so it is dropped too
    assign dm_rsp_valid = rsp_live & ~rsp_src & ~flush & ~reset;
    assign dm_rsp_id    = rsp_orig_id;
    assign dm_rsp_data  = ic_rsp_data;
    assign pf_rsp_valid = rsp_live & rsp_src & ~reset;
    assign pf_rsp_id    = rsp_orig_id;
    assign pf_rsp_data  = ic_rsp_data;

    assign busy = |slot_valid;

    // Slot table update: retire on response, kill demand slots on flush, then fill the granted slot
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid  <= '0;
            slot_src    <= '0;
            slot_killed <= '0;
            for (int i = 0; i < N_OUTST; i++) begin
                slot_orig_id[i] <= '0;
            end
        end else begin
            if (ic_rsp_valid) begin
                slot_valid[ic_rsp_id] <= 1'b0;
            end
            if (flush) begin
                slot_killed <= slot_killed | (slot_valid & ~slot_src);
            end
            if (grant) begin
                slot_valid[free_idx]   <= 1'b1;
                slot_src[free_idx]     <= pf_grant;
                slot_orig_id[free_idx] <= pf_grant ? pf_req_id : dm_req_id;
                slot_killed[free_idx]  <= 1'b0;
            end
        end
    end

    // Count back-to-back demand wins while the prefetcher waits; saturates at the limit
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (dm_grant && pf_req_valid) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if (pf_grant || !pf_req_valid) begin
            starve_cnt <= '0;
        end
    end

    rsp_to_live_slot: assert property (@(posedge clk) disable iff (reset)
        ic_rsp_valid |-> slot_valid[ic_rsp_id]);

endmodule

// File: tb/tb_icache_req_arb.sv
// tb/tb_icache_req_arb.sv - scoreboard bench for icache_req_arb
module tb_icache_req_arb;

    localparam int ID_W   = 4;
    localparam int SLOT_W = 2;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              dm_req_valid, dm_req_ready;
    logic [31:0]       dm_req_addr;
    logic [ID_W-1:0]   dm_req_id;
    logic              pf_req_valid, pf_req_ready;
    logic [31:0]       pf_req_addr;
    logic [ID_W-1:0]   pf_req_id;
    logic              flush;
    logic              ic_req_valid;
    logic [31:0]       ic_req_addr;
    logic [SLOT_W-1:0] ic_req_id;
    logic              ic_rsp_valid;
    logic [SLOT_W-1:0] ic_rsp_id;
    logic [LINE_W-1:0] ic_rsp_data;
    logic              dm_rsp_valid, pf_rsp_valid;
    logic [ID_W-1:0]   dm_rsp_id, pf_rsp_id;
    logic [LINE_W-1:0] dm_rsp_data, pf_rsp_data;
    logic              busy;

    icache_req_arb dut (
        .clk(clk), .reset(reset),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
        .dm_req_addr(dm_req_addr), .dm_req_id(dm_req_id),
        .pf_req_valid(pf_req_valid), .pf_req_ready(pf_req_ready),
        .pf_req_addr(pf_req_addr), .pf_req_id(pf_req_id),
        .flush(flush),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_id(ic_req_id),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_id(ic_rsp_id), .ic_rsp_data(ic_rsp_data),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_id(dm_rsp_id), .dm_rsp_data(dm_rsp_data),
        .pf_rsp_valid(pf_rsp_valid), .pf_rsp_id(pf_rsp_id), .pf_rsp_data(pf_rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [ID_W-1:0] id; } req_t;
    typedef struct { logic [31:0] addr; int slot; } gnt_t;
    typedef struct { logic [ID_W-1:0] id; logic [LINE_W-1:0] data; } rsp_t;
    typedef struct { int slot; logic [31:0] addr; int due; } pend_t;

    req_t  dm_q[$], pf_q[$];
    gnt_t  exp_gnt[$];
    rsp_t  exp_dm[$], exp_pf[$];
    pend_t pend[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_grants = 0;
    int last_grant_cyc = 0;
    int last_dm_rsp_cyc = 0;
    int ic_lat = 1;
    int ic_force_slot = -1;
    bit ic_hold = 0;
    bit ic_drop = 0;
    bit dm_acc = 0;
    bit pf_acc = 0;

    function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
        return {a ^ 32'h3333_0003, a ^ 32'h2222_0002, a ^ 32'h1111_0001, a ^ 32'hC0DE_0000};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic exp_g(input logic [31:0] a, input int s);
        exp_gnt.push_back('{addr: a, slot: s});
    endtask

    task automatic exp_d(input logic [ID_W-1:0] id, input logic [31:0] a);
        exp_dm.push_back('{id: id, data: line_of(a)});
    endtask

    task automatic exp_p(input logic [ID_W-1:0] id, input logic [31:0] a);
        exp_pf.push_back('{id: id, data: line_of(a)});
    endtask

    task automatic req_dm(input logic [31:0] a, input logic [ID_W-1:0] id);
        dm_q.push_back('{addr: a, id: id});
    endtask

    task automatic req_pf(input logic [31:0] a, input logic [ID_W-1:0] id);
        pf_q.push_back('{addr: a, id: id});
    endtask

    always @(posedge clk) cyc++;

    // Requesters: hold valid and payload until accepted, then load the next queued request
    always @(posedge clk) begin
        req_t r;
        #1;
        if (dm_req_valid && dm_acc) dm_req_valid = 1'b0;
        if (!dm_req_valid && dm_q.size() > 0) begin
            r = dm_q.pop_front();
            dm_req_addr = r.addr;
            dm_req_id = r.id;
            dm_req_valid = 1'b1;
        end
        if (pf_req_valid && pf_acc) pf_req_valid = 1'b0;
        if (!pf_req_valid && pf_q.size() > 0) begin
            r = pf_q.pop_front();
            pf_req_addr = r.addr;
            pf_req_id = r.id;
            pf_req_valid = 1'b1;
        end
    end

    // Icache model: fixed latency, optional hold, forced release of one slot, or drop-all
    always @(posedge clk) begin
        int sel;
        #1;
        ic_rsp_valid = 1'b0;
        sel = -1;
        if (ic_drop) begin
            pend.delete();
            ic_drop = 1'b0;
        end else begin
            for (int i = 0; i < pend.size(); i++) begin
                if (sel < 0) begin
                    if (ic_force_slot >= 0) begin
                        if (pend[i].slot == ic_force_slot) sel = i;
                    end else if (!ic_hold && pend[i].due <= cyc) begin
                        sel = i;
                    end
                end
            end
            if (sel >= 0) begin
                ic_rsp_valid = 1'b1;
                ic_rsp_id = SLOT_W'(pend[sel].slot);
                ic_rsp_data = line_of(pend[sel].addr);
                pend.delete(sel);
            end
            ic_force_slot = -1;
        end
    end

    // Monitor: compare every grant and every delivered response against the scoreboard
    always @(negedge clk) begin
        gnt_t g;
        rsp_t r;
        dm_acc = dm_req_valid & dm_req_ready;
        pf_acc = pf_req_valid & pf_req_ready;
        if (ic_req_valid) begin
            n_grants++;
            last_grant_cyc = cyc;
            if (exp_gnt.size() == 0) begin
                checks++; failures++;
                $display("FAIL gnt_unexpected actual addr=%0h slot=%0d required none", ic_req_addr, ic_req_id);
            end else begin
                g = exp_gnt.pop_front();
                check("gnt_addr", ic_req_addr, g.addr);
                check("gnt_slot", ic_req_id, g.slot);
            end
            pend.push_back('{slot: int'(ic_req_id), addr: ic_req_addr, due: cyc + ic_lat});
        end
        if (dm_rsp_valid) begin
            last_dm_rsp_cyc = cyc;
            if (exp_dm.size() == 0) begin
                checks++; failures++;
                $display("FAIL dm_rsp_unexpected actual id=%0h required none", dm_rsp_id);
            end else begin
                r = exp_dm.pop_front();
                check("dm_rsp_id", dm_rsp_id, r.id);
                check("dm_rsp_data", dm_rsp_data, r.data);
            end
        end
        if (pf_rsp_valid) begin
            if (exp_pf.size() == 0) begin
                checks++; failures++;
                $display("FAIL pf_rsp_unexpected actual id=%0h required none", pf_rsp_id);
            end else begin
                r = exp_pf.pop_front();
                check("pf_rsp_id", pf_rsp_id, r.id);
                check("pf_rsp_data", pf_rsp_data, r.data);
            end
        end
    end

    task automatic wait_grants(input int target, input string name);
        int n = 0;
        while (n_grants < target && n < 200) begin
            @(negedge clk); #1; n++;
        end
        check(name, n_grants, target);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        bit idle = 0;
        while (!idle && n < 500) begin
            @(negedge clk); #1; n++;
            idle = dm_q.size() == 0 && pf_q.size() == 0 && !dm_req_valid && !pf_req_valid
                   && pend.size() == 0 && !ic_rsp_valid && !busy;
        end
        check(name, idle, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        reset = 1'b1; flush = 1'b0;
        dm_req_valid = 1'b0; dm_req_addr = '0; dm_req_id = '0;
        pf_req_valid = 1'b0; pf_req_addr = '0; pf_req_id = '0;
        ic_rsp_valid = 1'b0; ic_rsp_id = '0; ic_rsp_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dm_ready", dm_req_ready, 1'b0);
        check("rst_pf_ready", pf_req_ready, 1'b0);
        check("rst_ic_valid", ic_req_valid, 1'b0);
        check("rst_dm_rsp", dm_rsp_valid, 1'b0);
        check("rst_pf_rsp", pf_rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("idle_dm_ready", dm_req_ready, 1'b1);
        check("idle_pf_ready", pf_req_ready, 1'b1);

        // Single demand, latency 1
        req_dm(32'h40, 4'h5); exp_g(32'h40, 0); exp_d(4'h5, 32'h40);
        wait_idle("t1_idle");
        check("t1_latency", last_dm_rsp_cyc - last_grant_cyc, 1);
        check("t1_busy", busy, 1'b0);

        // Starvation: D,D,D,P,D,D,D,P with slots alternating 0/1
        @(negedge clk);
        for (int i = 0; i < 6; i++) req_dm(32'h1000 + 32'(i) * 32'h40, ID_W'(i + 1));
        req_pf(32'h8000, 4'h9); req_pf(32'h8040, 4'hA);
        exp_g(32'h1000, 0); exp_g(32'h1040, 1); exp_g(32'h1080, 0); exp_g(32'h8000, 1);
        exp_g(32'h10C0, 0); exp_g(32'h1100, 1); exp_g(32'h1140, 0); exp_g(32'h8040, 1);
        for (int i = 0; i < 6; i++) exp_d(ID_W'(i + 1), 32'h1000 + 32'(i) * 32'h40);
        exp_p(4'h9, 32'h8000); exp_p(4'hA, 32'h8040);
        wait_idle("t2_idle");

        // Table full, then release slot 2 out of order
        @(negedge clk);
        ic_hold = 1'b1;
        g0 = n_grants;
        for (int i = 0; i < 5; i++) req_dm(32'h2000 + 32'(i) * 32'h40, ID_W'(i + 1));
        exp_g(32'h2000, 0); exp_g(32'h2040, 1); exp_g(32'h2080, 2); exp_g(32'h20C0, 3);
        exp_g(32'h2100, 2);
        exp_d(4'h3, 32'h2080); exp_d(4'h1, 32'h2000); exp_d(4'h2, 32'h2040);
        exp_d(4'h4, 32'h20C0); exp_d(4'h5, 32'h2100);
        wait_grants(g0 + 4, "t3_four_grants");
        @(negedge clk);
        check("t3_full_ready", dm_req_ready, 1'b0);
        check("t3_full_valid", dm_req_valid, 1'b1);
        check("t3_full_busy", busy, 1'b1);
        ic_force_slot = 2;
        @(negedge clk);
        check("t3_free_cycle_ready", dm_req_ready, 1'b0);
        check("t3_free_cycle_rsp", dm_rsp_valid, 1'b1);
        @(negedge clk);
        check("t3_reuse_valid", ic_req_valid, 1'b1);
        check("t3_reuse_slot", ic_req_id, 2'd2);
        ic_hold = 1'b0;
        wait_idle("t3_idle");

        // Flush kills two demand slots, prefetch survives
        @(negedge clk);
        ic_hold = 1'b1;
        g0 = n_grants;
        req_dm(32'h3000, 4'h1); req_dm(32'h3040, 4'h2); req_pf(32'hA000, 4'hC);
        exp_g(32'h3000, 0); exp_g(32'h3040, 1); exp_g(32'hA000, 2);
        exp_p(4'hC, 32'hA000);
        wait_grants(g0 + 3, "t4_three_grants");
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk);
        check("t4_flush_dm_ready", dm_req_ready, 1'b0);
        check("t4_flush_pf_ready", pf_req_ready, 1'b1);
        check("t4_flush_busy", busy, 1'b1);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        ic_hold = 1'b0;
        wait_idle("t4_idle");
        check("t4_busy", busy, 1'b0);

        // Flush cycle with both requesters valid: prefetch wins, demand follows
        @(negedge clk);
        req_dm(32'h4000, 4'h3); req_pf(32'hB000, 4'h4);
        exp_g(32'hB000, 0); exp_g(32'h4000, 1);
        exp_p(4'h4, 32'hB000); exp_d(4'h3, 32'h4000);
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk);
        check("t5_flush_dm_ready", dm_req_ready, 1'b0);
        check("t5_flush_pf_ready", pf_req_ready, 1'b1);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        check("t5_after_dm_ready", dm_req_ready, 1'b1);
        wait_idle("t5_idle");

        // Reset with three slots in flight, icache quiesced
        @(negedge clk);
        ic_hold = 1'b1;
        g0 = n_grants;
        req_dm(32'h5000, 4'h1); req_dm(32'h5040, 4'h2); req_dm(32'h5080, 4'h3);
        exp_g(32'h5000, 0); exp_g(32'h5040, 1); exp_g(32'h5080, 2);
        wait_grants(g0 + 3, "t6_three_grants");
        ic_drop = 1'b1;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        check("t6_rst_dm_ready", dm_req_ready, 1'b0);
        check("t6_rst_pf_ready", pf_req_ready, 1'b0);
        req_dm(32'h9000, 4'h7);
        exp_g(32'h9000, 0); exp_d(4'h7, 32'h9000);
        ic_hold = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_valid_held", dm_req_valid, 1'b1);
        check("t6_rst_dm_ready2", dm_req_ready, 1'b0);
        check("t6_rst_ic_valid", ic_req_valid, 1'b0);
        @(posedge clk); #1; reset = 1'b0;
        wait_idle("t6_idle");

        check("end_gnt_left", exp_gnt.size(), 0);
        check("end_dm_left", exp_dm.size(), 0);
        check("end_pf_left", exp_pf.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
